// File: rtl/adc_pkg.sv
// Shared types, widths and channel helpers for the LTC2308 scan controller.
package adc_pkg;

    localparam int RESULT_W = 12;
    localparam int CFG_W    = 6;
    localparam int N_CH     = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVST,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } adc_state_e;

    // Config word {S/D=1, O/S, S1, S0, UNI, SLP=0}; O/S is the channel LSB.
    function automatic logic [CFG_W-1:0] cfg_word(input logic [2:0] ch, input logic uni);
        return {1'b1, ch[0], ch[2], ch[1], uni, 1'b0};
    endfunction

    // Next set bit of mask after ch, wrapping; returns ch itself for a one-hot mask.
    function automatic logic [2:0] next_ch(input logic [N_CH-1:0] mask, input logic [2:0] ch);
        logic [2:0] c;
        logic [2:0] r;
        logic       hit;
        r   = ch;
        hit = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            c = ch + 3'(i);
            if (!hit && mask[c]) begin
                r   = c;
                hit = 1'b1;
            end
        end
        return r;
    endfunction

    // Highest set bit of mask; its write closes a scan.
    function automatic logic [2:0] last_ch(input logic [N_CH-1:0] mask);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (mask[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_scan_ctrl_if.sv
// Control and sample bus between the scan controller and its consumers.
interface adc_scan_ctrl_if;
    import adc_pkg::*;

    logic                               cont;
    logic                               start;
    logic                               busy;
    logic                               sample_valid;
    logic [2:0]                         sample_ch;
    logic [RESULT_W-1:0]                sample_data;
    logic                               scan_done;
    logic [N_CH-1:0][RESULT_W-1:0]      results;

    modport master (
        input  cont, start,
        output busy, sample_valid, sample_ch, sample_data, scan_done, results
    );

    modport slave (
        output cont, start,
        input  busy, sample_valid, sample_ch, sample_data, scan_done, results
    );

endinterface

// File: rtl/adc_frame.sv
// One LTC2308 frame: CONVST pulse, conversion wait, 12-bit SCK shift, DONE.
// All pins are registered from the next-state values so they line up with the state.
module adc_frame
    import adc_pkg::*;
#(
    parameter int SCK_HALF    = 2,
    parameter int CONV_CYCLES = 80
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                go,
    input  logic [CFG_W-1:0]    cfg,
    output logic                done,
    output logic [RESULT_W-1:0] data,
    output logic                convst,
    output logic                sck,
    output logic                sdi,
    input  logic                sdo
);

    adc_state_e          state, state_nx;
    logic [15:0]         cnt, cnt_nx;
    logic [4:0]          hx, hx_nx;      // SCK half-period index 0..23 inside SHIFT
    logic                sck_d, sdi_d;
    logic [RESULT_W-1:0] word;

    assign word = {cfg, {(RESULT_W-CFG_W){1'b0}}};
    assign done = (state == S_DONE);

    // SCK is high on odd halves, so it idles low and rises mid-period
    assign sck_d = (state_nx == S_SHIFT) && hx_nx[0];
    // one SDI bit per SCK period, MSB valid on SHIFT entry, changes where SCK falls
    assign sdi_d = (state_nx == S_SHIFT) && word[4'(RESULT_W-1) - hx_nx[4:1]];

    // state register and phase counters
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            hx    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            hx    <= hx_nx;
        end
    end

    // next-state and counter sequencing for the frame phases
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 16'd1;
        hx_nx    = hx;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                hx_nx  = '0;
                if (go) state_nx = S_CONVST;
            end
            S_CONVST: begin
                if (cnt == 16'd1) begin
                    cnt_nx   = '0;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 16'(CONV_CYCLES-1)) begin
                    cnt_nx   = '0;
                    hx_nx    = '0;
                    state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt == 16'(SCK_HALF-1)) begin
                    cnt_nx = '0;
                    hx_nx  = hx + 5'd1;
                    if (hx == 5'd23) begin
                        hx_nx    = '0;
                        state_nx = S_DONE;
                    end
                end
            end
            S_DONE: begin
                cnt_nx   = '0;
                hx_nx    = '0;
                state_nx = go ? S_CONVST : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // pin registers; SDO is taken on the edge that raises SCK
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            convst <= 1'b0;
            sck    <= 1'b0;
            sdi    <= 1'b0;
            data   <= '0;
        end else begin
            convst <= (state_nx == S_CONVST);
            sck    <= sck_d;
            sdi    <= sdi_d;
            if (sck_d && !sck) data <= {data[RESULT_W-2:0], sdo};
        end
    end

endmodule

// File: rtl/adc_scan_ctrl.sv
// LTC2308 scan controller: sequences channels, tags pipelined results and keeps the result bank.
// The result read in a frame belongs to the config sent one frame earlier, hence prev_ch.
module adc_scan_ctrl
    import adc_pkg::*;
#(
    parameter logic [N_CH-1:0] CH_MASK     = 8'b0010_0010,
    parameter int              SCK_HALF    = 2,
    parameter int              CONV_CYCLES = 80,
    parameter logic            UNIPOLAR    = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    adc_scan_ctrl_if.master scan,
    output logic            ADC_CONVST,
    output logic            ADC_SCK,
    output logic            ADC_SDI,
    input  logic            ADC_SDO
);

    if (CH_MASK == '0) begin : g_bad_mask
        $error("adc_scan_ctrl: CH_MASK must select at least one channel");
    end

    localparam logic [2:0] LO_CH = next_ch(CH_MASK, 3'd7);
    localparam logic [2:0] HI_CH = last_ch(CH_MASK);

    logic                          busy, priming, last, go, done;
    logic [2:0]                    cfg_ch, prev_ch;
    logic [CFG_W-1:0]              cfg;
    logic [RESULT_W-1:0]           data;
    logic                          sample_valid, scan_done;
    logic [2:0]                    sample_ch;
    logic [RESULT_W-1:0]           sample_data;
    logic [N_CH-1:0][RESULT_W-1:0] results;

    assign cfg  = cfg_word(cfg_ch, UNIPOLAR);
    // the frame now ending delivers the highest channel of the scan
    assign last = !priming && (prev_ch == HI_CH);
    // idle: start on cont or start; running: chain frames unless a single scan just closed
    assign go   = busy ? (done && (scan.cont || !last)) : (scan.cont || scan.start);

    adc_frame #(
        .SCK_HALF    (SCK_HALF),
        .CONV_CYCLES (CONV_CYCLES)
    ) u_frame (
        .clk     (clk),
        .reset_n (reset_n),
        .go      (go),
        .cfg     (cfg),
        .done    (done),
        .data    (data),
        .convst  (ADC_CONVST),
        .sck     (ADC_SCK),
        .sdi     (ADC_SDI),
        .sdo     (ADC_SDO)
    );

    // channel sequencing, result tagging and the per-channel bank
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy         <= 1'b0;
            priming      <= 1'b1;
            cfg_ch       <= LO_CH;
            prev_ch      <= '0;
            sample_valid <= 1'b0;
            scan_done    <= 1'b0;
            sample_ch    <= '0;
            sample_data  <= '0;
            results      <= '0;
        end else begin
            sample_valid <= 1'b0;
            scan_done    <= 1'b0;
            if (!busy) begin
                cfg_ch  <= LO_CH;
                priming <= 1'b1;
                if (go) busy <= 1'b1;
            end else if (done) begin
                if (!priming) begin
                    results[prev_ch] <= data;
                    sample_valid     <= 1'b1;
                    sample_ch        <= prev_ch;
                    sample_data      <= data;
                    scan_done        <= (prev_ch == HI_CH);
                end
                prev_ch <= cfg_ch;
                cfg_ch  <= next_ch(CH_MASK, cfg_ch);
                priming <= 1'b0;
                if (!go) busy <= 1'b0;
            end
        end
    end

    assign scan.busy         = busy;
    assign scan.sample_valid = sample_valid;
    assign scan.sample_ch    = sample_ch;
    assign scan.sample_data  = sample_data;
    assign scan.scan_done    = scan_done;
    assign scan.results      = results;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench for adc_scan_ctrl: four instances (default, all channels, single scan, fast timing)
// each driven by a small LTC2308 model that answers with the previous frame's channel.
module tb_adc_scan_ctrl;
    import adc_pkg::*;

    logic       clk = 1'b0;
    logic [3:0] rst_n = '0;
    logic [3:0] convst, sck, sdi, sdo;
    logic [3:0] sv;
    int         n_chk = 0;
    int         n_pass = 0;
    logic [5:0] cfg_exp [8] = '{6'h22, 6'h32, 6'h26, 6'h36, 6'h2A, 6'h3A, 6'h2E, 6'h3E};

    always #5 clk = ~clk;

    adc_scan_ctrl_if b0 ();
    adc_scan_ctrl_if b1 ();
    adc_scan_ctrl_if b2 ();
    adc_scan_ctrl_if b3 ();

    adc_scan_ctrl u0 (
        .clk(clk), .reset_n(rst_n[0]), .scan(b0),
        .ADC_CONVST(convst[0]), .ADC_SCK(sck[0]), .ADC_SDI(sdi[0]), .ADC_SDO(sdo[0]));
    adc_scan_ctrl #(.CH_MASK(8'hFF)) u1 (
        .clk(clk), .reset_n(rst_n[1]), .scan(b1),
        .ADC_CONVST(convst[1]), .ADC_SCK(sck[1]), .ADC_SDI(sdi[1]), .ADC_SDO(sdo[1]));
    adc_scan_ctrl #(.CH_MASK(8'h05)) u2 (
        .clk(clk), .reset_n(rst_n[2]), .scan(b2),
        .ADC_CONVST(convst[2]), .ADC_SCK(sck[2]), .ADC_SDI(sdi[2]), .ADC_SDO(sdo[2]));
    adc_scan_ctrl #(.SCK_HALF(1), .CONV_CYCLES(1)) u3 (
        .clk(clk), .reset_n(rst_n[3]), .scan(b3),
        .ADC_CONVST(convst[3]), .ADC_SCK(sck[3]), .ADC_SDI(sdi[3]), .ADC_SDO(sdo[3]));

    assign sv = {b3.sample_valid, b2.sample_valid, b1.sample_valid, b0.sample_valid};

    // value the ADC returns for a channel, per instance
    function automatic logic [11:0] mdl_val(input int g, input logic [2:0] ch);
        case (g)
            0:       return (ch == 3'd1) ? 12'hA5C : (ch == 3'd5) ? 12'h3F0 : 12'h000;
            1:       return {1'b0, ch, 8'hC3};
            2:       return (ch == 3'd0) ? 12'h123 : (ch == 3'd2) ? 12'h456 : 12'h000;
            default: return 12'h801;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_mdl
        logic [5:0]  cap = '0;
        logic [5:0]  last_cfg = '0;
        logic [11:0] out = '0;
        logic        pc = 1'b0;
        logic        ps = 1'b0;
        int          rises = 0;
        logic [5:0]  cap_q [$];

        assign sdo[g] = out[11];

        // load on CONVST rise, capture config on SCK rise, shift data out on SCK fall
        always @(convst[g], sck[g]) begin
            if (convst[g] === 1'b1 && pc !== 1'b1) begin
                out   = mdl_val(g, {last_cfg[3], last_cfg[2], last_cfg[4]});
                rises = 0;
            end
            if (sck[g] === 1'b1 && ps !== 1'b1) begin
                if (rises < 6) cap = {cap[4:0], sdi[g]};
                rises++;
                if (rises == 6) begin
                    last_cfg = cap;
                    cap_q.push_back(cap);
                end
            end
            if (sck[g] === 1'b0 && ps === 1'b1) out = {out[10:0], 1'b0};
            pc = convst[g];
            ps = sck[g];
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    endtask

    // advance at least one cycle, stop on sample_valid of instance g or at limit
    task automatic wait_sv(input int g, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sv[g] && n < limit);
    endtask

    initial begin
        int          n, r, nsv, ndone, bfall;
        logic        p;
        logic [2:0]  ch_a, ch_b;
        logic [11:0] d_a, d_b;
        logic        dn_b;

        b0.cont = 0; b0.start = 0;
        b1.cont = 0; b1.start = 0;
        b2.cont = 0; b2.start = 0;
        b3.cont = 0; b3.start = 0;
        repeat (3) @(negedge clk);

        chk("rst_busy",  int'(b0.busy), 0);
        chk("rst_valid", int'(sv), 0);
        chk("rst_done",  int'(b0.scan_done), 0);
        chk("rst_ch",    int'(b0.sample_ch), 0);
        chk("rst_data",  int'(b0.sample_data), 0);
        chk("rst_pins",  int'({convst, sck, sdi}), 0);
        chk("rst_res",   int'(b0.results != '0), 0);
        rst_n = '1;
        @(negedge clk);

        // continuous scan, default mask {1,5}
        b0.cont = 1;
        @(negedge clk);
        chk("t1_busy",   int'(b0.busy), 1);
        chk("t1_convst", int'(convst[0]), 1);
        wait_sv(0, 400, n);
        chk("t1_first_lat", n, 262);
        chk("t1_s1_ch",   int'(b0.sample_ch), 1);
        chk("t1_s1_data", int'(b0.sample_data), 'hA5C);
        chk("t1_s1_done", int'(b0.scan_done), 0);
        wait_sv(0, 200, n);
        chk("t1_period",  n, 131);
        chk("t1_s2_ch",   int'(b0.sample_ch), 5);
        chk("t1_s2_data", int'(b0.sample_data), 'h3F0);
        chk("t1_s2_done", int'(b0.scan_done), 1);
        chk("t1_res1",    int'(b0.results[1]), 'hA5C);
        chk("t1_res5",    int'(b0.results[5]), 'h3F0);
        chk("t1_res0",    int'(b0.results[0]), 0);
        wait_sv(0, 200, n);
        chk("t1_s3_ch",   int'(b0.sample_ch), 1);
        chk("t1_s3_done", int'(b0.scan_done), 0);

        // reset at the 6th SCK rise of the frame that just began
        r = 0; n = 0; p = sck[0];
        while (r < 6 && n < 300) begin
            @(negedge clk);
            n++;
            if (sck[0] && !p) r++;
            p = sck[0];
        end
        chk("mid_rises", r, 6);
        rst_n[0] = 0;
        b0.cont  = 0;
        @(negedge clk);
        chk("mid_sck",    int'(sck[0]), 0);
        chk("mid_convst", int'(convst[0]), 0);
        chk("mid_busy",   int'(b0.busy), 0);
        chk("mid_res",    int'(b0.results != '0), 0);
        @(negedge clk);
        rst_n[0] = 1;
        nsv = 0;
        repeat (300) begin
            @(negedge clk);
            if (sv[0]) nsv++;
        end
        chk("mid_nsv", nsv, 0);

        // all eight channels: SDI config words in scan order
        b1.cont = 1;
        n = 0;
        while (g_mdl[1].cap_q.size() < 9 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t2_frames", int'(g_mdl[1].cap_q.size() >= 9), 1);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t2_cfg_ch%0d", i), int'(g_mdl[1].cap_q[i]), int'(cfg_exp[i]));
        chk("t2_res3", int'(b1.results[3]), 'h3C3);
        b1.cont = 0;

        // single scan of {0,2}; a second start mid-scan is ignored
        ch_a = 3'd7; ch_b = 3'd0; d_a = '0; d_b = '0; dn_b = 1'b0;
        nsv = 0; ndone = 0; bfall = -1;
        b2.start = 1;
        @(negedge clk);
        b2.start = 0;
        chk("t3_busy", int'(b2.busy), 1);
        for (int c = 0; c < 600; c++) begin
            if (sv[2]) begin
                if (nsv == 0) begin
                    ch_a = b2.sample_ch; d_a = b2.sample_data;
                end else begin
                    ch_b = b2.sample_ch; d_b = b2.sample_data; dn_b = b2.scan_done;
                end
                nsv++;
            end
            if (b2.scan_done) ndone++;
            if (!b2.busy && bfall < 0) bfall = c;
            b2.start = (c == 50);
            @(negedge clk);
        end
        chk("t3_nsv",     nsv, 2);
        chk("t3_s1_ch",   int'(ch_a), 0);
        chk("t3_s1_data", int'(d_a), 'h123);
        chk("t3_s2_ch",   int'(ch_b), 2);
        chk("t3_s2_data", int'(d_b), 'h456);
        chk("t3_s2_done", int'(dn_b), 1);
        chk("t3_ndone",   ndone, 1);
        chk("t3_busy_end", bfall, 393);
        chk("t3_res0",    int'(b2.results[0]), 'h123);
        chk("t3_res2",    int'(b2.results[2]), 'h456);

        // fastest timing: 28-cycle frames, 0x801 exercises both ends of the word
        b3.cont = 1;
        @(negedge clk);
        wait_sv(3, 100, n);
        chk("t4_first_lat", n, 56);
        chk("t4_s1_ch",   int'(b3.sample_ch), 1);
        chk("t4_s1_data", int'(b3.sample_data), 'h801);
        wait_sv(3, 60, n);
        chk("t4_period",  n, 28);
        chk("t4_s2_ch",   int'(b3.sample_ch), 5);
        chk("t4_s2_data", int'(b3.sample_data), 'h801);
        b3.cont = 0;
        repeat (60) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
